// File: rtl/user_id_ctrl.sv
// Sequencing and access controller for the user project ID word: settles, double-samples
// the ID cell array, then serves the captured word to a bus read port and a serial dump port.
module user_id_ctrl #(
  parameter int SETTLE_CYCLES = 8,
  parameter int SHIFT_DIV     = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] mask_rev_i,
  input  logic        rd_req,
  output logic        rd_ack,
  output logic [31:0] rd_data,
  input  logic        ser_start,
  output logic        ser_busy,
  output logic        ser_dout,
  input  logic        refresh_req,
  output logic        id_valid,
  output logic [31:0] id_q,
  output logic [3:0]  mismatch_cnt
);

  localparam logic [1:0] ST_SETTLE  = 2'd0;
  localparam logic [1:0] ST_SAMPLE1 = 2'd1;
  localparam logic [1:0] ST_SAMPLE2 = 2'd2;
  localparam logic [1:0] ST_READY   = 2'd3;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] DIV_LAST    = 8'(SHIFT_DIV - 1);

  logic [1:0]  state;
  logic [7:0]  settle_cnt;
  logic        refresh_pend;
  logic [31:0] shift_q;
  logic [4:0]  bit_cnt;
  logic [7:0]  div_cnt;

  logic in_ready;
  logic ack_due;
  logic refresh_take;
  logic ser_accept;

  assign in_ready = (state == ST_READY);
  // A read ack due next cycle outranks a refresh, so the refresh waits one cycle.
  assign ack_due      = in_ready && rd_req && !rd_ack;
  assign refresh_take = in_ready && (refresh_req || refresh_pend) && !ser_busy && !ack_due;
  assign ser_accept   = in_ready && ser_start && !ser_busy && !refresh_take;

  // NOTE: all state is updated with non-blocking assignments so every register samples
  // the pre-edge values of its neighbours; blocking here would create ordering races.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= ST_SETTLE;
      settle_cnt   <= 8'd0;
      id_q         <= 32'd0;
      id_valid     <= 1'b0;
      mismatch_cnt <= 4'd0;
    end else begin
      case (state)
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state      <= ST_SAMPLE1;
            settle_cnt <= 8'd0;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        ST_SAMPLE1: begin
          id_q  <= mask_rev_i;
          state <= ST_SAMPLE2;
        end
        ST_SAMPLE2: begin
          if (mask_rev_i == id_q) begin
            state    <= ST_READY;
            id_valid <= 1'b1;
          end else begin
            state <= ST_SETTLE;
            if (mismatch_cnt != 4'hF) mismatch_cnt <= mismatch_cnt + 4'd1;
          end
        end
        ST_READY: begin
          if (refresh_take) begin
            state    <= ST_SETTLE;
            id_valid <= 1'b0;
          end
        end
        default: begin
          state    <= ST_SETTLE;
          id_valid <= 1'b0;
        end
      endcase
    end
  end

  // Refresh requests that cannot be taken immediately (dump active or ack due) are held.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      refresh_pend <= 1'b0;
    end else if (refresh_take) begin
      refresh_pend <= 1'b0;
    end else if (in_ready && refresh_req) begin
      refresh_pend <= 1'b1;
    end
  end

  // Gating on the current ack enforces at most one ack every two cycles.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rd_ack  <= 1'b0;
      rd_data <= 32'd0;
    end else if (ack_due) begin
      rd_ack  <= 1'b1;
      rd_data <= id_q;
    end else begin
      rd_ack  <= 1'b0;
      rd_data <= 32'd0;
    end
  end

  // shift_q holds the bits still to be sent, MSB-aligned, taken from a snapshot at start.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ser_busy <= 1'b0;
      ser_dout <= 1'b0;
      shift_q  <= 32'd0;
      bit_cnt  <= 5'd0;
      div_cnt  <= 8'd0;
    end else if (ser_accept) begin
      ser_busy <= 1'b1;
      ser_dout <= id_q[31];
      shift_q  <= {id_q[30:0], 1'b0};
      bit_cnt  <= 5'd31;
      div_cnt  <= 8'd0;
    end else if (ser_busy) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= 8'd0;
        if (bit_cnt == 5'd0) begin
          ser_busy <= 1'b0;
          ser_dout <= 1'b0;
        end else begin
          bit_cnt  <= bit_cnt - 5'd1;
          ser_dout <= shift_q[31];
          shift_q  <= {shift_q[30:0], 1'b0};
        end
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_user_id_ctrl.sv
// Directed self-checking bench for user_id_ctrl (SETTLE_CYCLES=8, SHIFT_DIV=4).
module tb_user_id_ctrl;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [31:0] mask_rev_i;
  logic        rd_req;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic        ser_start;
  logic        ser_busy;
  logic        ser_dout;
  logic        refresh_req;
  logic        id_valid;
  logic [31:0] id_q;
  logic [3:0]  mismatch_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  user_id_ctrl #(.SETTLE_CYCLES(8), .SHIFT_DIV(4)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .mask_rev_i  (mask_rev_i),
    .rd_req      (rd_req),
    .rd_ack      (rd_ack),
    .rd_data     (rd_data),
    .ser_start   (ser_start),
    .ser_busy    (ser_busy),
    .ser_dout    (ser_dout),
    .refresh_req (refresh_req),
    .id_valid    (id_valid),
    .id_q        (id_q),
    .mismatch_cnt(mismatch_cnt)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Advance one rising edge and settle past it before sampling or driving.
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_all_reset(input string tag);
    check({tag, " rd_ack"},   32'(rd_ack),       32'd0);
    check({tag, " rd_data"},  rd_data,           32'd0);
    check({tag, " ser_busy"}, 32'(ser_busy),     32'd0);
    check({tag, " ser_dout"}, 32'(ser_dout),     32'd0);
    check({tag, " id_valid"}, 32'(id_valid),     32'd0);
    check({tag, " id_q"},     id_q,              32'd0);
    check({tag, " mismatch"}, 32'(mismatch_cnt), 32'd0);
  endtask

  initial begin
    wb_rst_i    = 1'b1;
    mask_rev_i  = 32'hA5C3_0F1E;
    rd_req      = 1'b0;
    ser_start   = 1'b0;
    refresh_req = 1'b0;

    // Reset values and initial capture latency.
    repeat (3) tick();
    check_all_reset("reset");
    wb_rst_i = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("init valid low", 32'(id_valid), 32'd0);
    end
    tick();
    check("init valid rise", 32'(id_valid), 32'd1);
    check("init id_q", id_q, 32'hA5C3_0F1E);
    check("init mismatch", 32'(mismatch_cnt), 32'd0);

    // Two mismatching attempts, then a stable word.
    wb_rst_i = 1'b1;
    mask_rev_i = 32'h1111_1111;
    tick();
    wb_rst_i = 1'b0;
    repeat (9) tick();
    check("mm1 sample1 id_q", id_q, 32'h1111_1111);
    mask_rev_i = 32'h2222_2222;
    tick();
    check("mm1 count", 32'(mismatch_cnt), 32'd1);
    check("mm1 valid", 32'(id_valid), 32'd0);
    repeat (9) tick();
    check("mm2 sample1 id_q", id_q, 32'h2222_2222);
    mask_rev_i = 32'h3333_3333;
    tick();
    check("mm2 count", 32'(mismatch_cnt), 32'd2);
    mask_rev_i = 32'h1234_5678;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("mm3 valid low", 32'(id_valid), 32'd0);
    end
    tick();
    check("mm3 valid rise", 32'(id_valid), 32'd1);
    check("mm3 id_q", id_q, 32'h1234_5678);
    check("mm3 count", 32'(mismatch_cnt), 32'd2);

    // Reset asserted mid-dump with a read ack due on the same edge.
    ser_start = 1'b1;
    tick();
    check("rstmid busy", 32'(ser_busy), 32'd1);
    ser_start = 1'b0;
    repeat (5) tick();
    rd_req   = 1'b1;
    wb_rst_i = 1'b1;
    tick();
    check_all_reset("rst mid");

    // Read request held from reset.
    tick();
    check("hold rst ack", 32'(rd_ack), 32'd0);
    wb_rst_i = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("hold stalled ack", 32'(rd_ack), 32'd0);
    end
    check("hold valid", 32'(id_valid), 32'd1);
    tick();
    check("hold ack1", 32'(rd_ack), 32'd1);
    check("hold data1", rd_data, 32'h1234_5678);
    tick();
    check("hold gap ack", 32'(rd_ack), 32'd0);
    check("hold gap data", rd_data, 32'd0);
    tick();
    check("hold ack2", 32'(rd_ack), 32'd1);
    check("hold data2", rd_data, 32'h1234_5678);
    tick();
    check("hold gap2 ack", 32'(rd_ack), 32'd0);
    rd_req = 1'b0;
    tick();
    check("hold released ack", 32'(rd_ack), 32'd0);

    // Serial dump of 32'h8000_0001 with an ignored mid-dump start.
    wb_rst_i = 1'b1;
    mask_rev_i = 32'h8000_0001;
    tick();
    wb_rst_i = 1'b0;
    repeat (10) tick();
    check("dump valid", 32'(id_valid), 32'd1);
    check("dump id_q", id_q, 32'h8000_0001);
    ser_start = 1'b1;
    for (int k = 1; k <= 128; k++) begin
      tick();
      ser_start = (k == 50);
      check("dump busy", 32'(ser_busy), 32'd1);
      check("dump dout", 32'(ser_dout), 32'((k <= 4) || (k >= 125)));
    end
    tick();
    check("dump end busy", 32'(ser_busy), 32'd0);
    check("dump end dout", 32'(ser_dout), 32'd0);

    // Refresh at dump cycle 10 with a simultaneous read.
    ser_start = 1'b1;
    tick();
    ser_start = 1'b0;
    repeat (9) tick();
    refresh_req = 1'b1;
    rd_req      = 1'b1;
    tick();
    refresh_req = 1'b0;
    rd_req      = 1'b0;
    check("ref dump ack", 32'(rd_ack), 32'd1);
    check("ref dump data", rd_data, 32'h8000_0001);
    for (int k = 12; k <= 128; k++) begin
      tick();
      check("ref dump valid held", 32'(id_valid), 32'd1);
    end
    check("ref dump last busy", 32'(ser_busy), 32'd1);
    tick();
    check("ref busy fell", 32'(ser_busy), 32'd0);
    check("ref valid after fall", 32'(id_valid), 32'd1);
    tick();
    check("ref taken", 32'(id_valid), 32'd0);
    repeat (9) tick();
    check("ref recap low", 32'(id_valid), 32'd0);
    tick();
    check("ref recap rise", 32'(id_valid), 32'd1);

    // Refresh deferred by a due read ack, then SETTLE-time requests ignored.
    refresh_req = 1'b1;
    rd_req      = 1'b1;
    tick();
    refresh_req = 1'b0;
    rd_req      = 1'b0;
    check("defer ack", 32'(rd_ack), 32'd1);
    check("defer valid held", 32'(id_valid), 32'd1);
    tick();
    check("defer taken", 32'(id_valid), 32'd0);
    check("defer ack low", 32'(rd_ack), 32'd0);
    ser_start = 1'b1;
    tick();
    ser_start = 1'b0;
    check("settle start ignored", 32'(ser_busy), 32'd0);
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    for (int i = 3; i <= 9; i++) begin
      tick();
      check("settle refresh low", 32'(id_valid), 32'd0);
    end
    tick();
    check("settle refresh rise", 32'(id_valid), 32'd1);
    tick();
    check("no stale pending", 32'(id_valid), 32'd1);

    // Immediate refresh in idle READY.
    refresh_req = 1'b1;
    tick();
    refresh_req = 1'b0;
    check("imm taken", 32'(id_valid), 32'd0);
    repeat (9) tick();
    check("imm low", 32'(id_valid), 32'd0);
    tick();
    check("imm rise", 32'(id_valid), 32'd1);
    check("imm mismatch kept", 32'(mismatch_cnt), 32'd0);
    check("imm id_q", id_q, 32'h8000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
